// File: rtl/press_classifier_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : press_classifier_if
//  Purpose  : Button-side bundle for the press classifier. It carries the
//             debounced level and tick strobe in, and the classification
//             pulses and press counter out.
//  Revision : 1.0  initial release
// ============================================================================
interface press_classifier_if #(
    parameter int CW = 8
);
    logic          db;
    logic          tick;
    logic          short_p;
    logic          long_p;
    logic          double_p;
    logic [CW-1:0] press_cnt;

    // Stimulus side: drives the switch level and the tick strobe
    modport master (
        output db,
        output tick,
        input  short_p,
        input  long_p,
        input  double_p,
        input  press_cnt
    );

    // Classifier side: consumes the switch level and tick, produces results
    modport slave (
        input  db,
        input  tick,
        output short_p,
        output long_p,
        output double_p,
        output press_cnt
    );
endinterface
`default_nettype wire

// File: rtl/press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : press_classifier
//  Purpose  : Classifies a debounced push button into short, long and double
//             presses using a slow tick strobe as the time base, and counts
//             every accepted press.
//  Revision : 1.0  initial release
// ============================================================================
module press_classifier #(
    parameter int LONG_TICKS = 100,
    parameter int GAP_TICKS  = 30,
    parameter int CW         = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    press_classifier_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter value at which the tick in progress completes the interval.
    localparam logic [CW-1:0] c_long_last = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] c_gap_last  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    // ------------------------------------------------------------------------
    // State encoding
    //   IDLE  : button released, nothing pending
    //   HELD  : first press in progress, timing towards a long press
    //   LONG  : long press reported, waiting for release
    //   GAP   : first press released, waiting for a second press or timeout
    //   HELD2 : second press in progress
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HELD  = 3'd1,
        S_LONG  = 3'd2,
        S_GAP   = 3'd3,
        S_HELD2 = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_db_q;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_press_cnt;
    logic          r_short_p;
    logic          r_long_p;
    logic          r_double_p;

    logic          w_rise;
    logic          w_fall;
    logic          w_cnt_run;
    logic          w_long_expire;
    logic          w_gap_expire;
    logic          w_short;
    logic          w_long;
    logic          w_double;
    logic          w_accept;

    // ------------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------------
    // The delayed level resets high so a button already held when reset is
    // released does not look like a fresh rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_q <= 1'b1;
        end else begin
            r_db_q <= bus.db;
        end
    end

    assign w_rise = bus.db & ~r_db_q;
    assign w_fall = ~bus.db & r_db_q;

    // ------------------------------------------------------------------------
    // Tick interval decode
    // ------------------------------------------------------------------------
    // The counter only advances in the timed states; LONG and IDLE wait on
    // edges alone.
    assign w_cnt_run     = (r_state == S_HELD) || (r_state == S_GAP) ||
                           (r_state == S_HELD2);
    assign w_long_expire = bus.tick && (r_cnt == c_long_last);
    assign w_gap_expire  = bus.tick && (r_cnt == c_gap_last);

    // ------------------------------------------------------------------------
    // Next-state and pulse decode
    // ------------------------------------------------------------------------
    // Edges are tested before tick expiry in every state so that an edge
    // arriving with a tick always takes the edge transition and the tick is
    // dropped without producing an expiry pulse.
    always_comb begin
        w_next_state = r_state;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_double     = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next_state = S_HELD;
                    w_accept     = 1'b1;
                end
            end

            S_HELD: begin
                if (w_fall) begin
                    w_next_state = S_GAP;
                end else if (w_long_expire) begin
                    w_next_state = S_LONG;
                    w_long       = 1'b1;
                end
            end

            S_LONG: begin
                // Release after a long press is silent.
                if (w_fall) begin
                    w_next_state = S_IDLE;
                end
            end

            S_GAP: begin
                if (w_rise) begin
                    w_next_state = S_HELD2;
                    w_accept     = 1'b1;
                end else if (w_gap_expire) begin
                    w_next_state = S_IDLE;
                    w_short      = 1'b1;
                end
            end

            S_HELD2: begin
                // A second press held long enough turns into a plain long
                // press; the first press is then discarded.
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_double     = 1'b1;
                end else if (w_long_expire) begin
                    w_next_state = S_LONG;
                    w_long       = 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Holds the classifier state; reset aborts any press in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Tick counter
    // ------------------------------------------------------------------------
    // Cleared on every state change so each timed state measures from its
    // own entry; it never wraps because every timed state leaves on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (bus.tick && w_cnt_run) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------------
    // Classification pulses
    // ------------------------------------------------------------------------
    // Registered so each pulse lasts one clock, rises on the transition edge
    // and leaves no combinational path from db or tick to the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_short_p  <= 1'b0;
            r_long_p   <= 1'b0;
            r_double_p <= 1'b0;
        end else begin
            r_short_p  <= w_short;
            r_long_p   <= w_long;
            r_double_p <= w_double;
        end
    end

    // ------------------------------------------------------------------------
    // Press counter
    // ------------------------------------------------------------------------
    // Counts accepted rising edges and wraps naturally at the counter width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press_cnt <= '0;
        end else if (w_accept) begin
            r_press_cnt <= r_press_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.short_p   = r_short_p;
    assign bus.long_p    = r_long_p;
    assign bus.double_p  = r_double_p;
    assign bus.press_cnt = r_press_cnt;

endmodule
`default_nettype wire

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 100: hold length, in tick strobes, that classifies a press as long (1 s at 10 ms tick).
REQ-002 SHALL have parameter GAP_TICKS, default 30: release window, in tick strobes, in which a second press makes a double press.
REQ-003 SHALL have parameter CW, default 8: width of press_cnt and of the internal tick counter.
REQ-004 SHALL have ports: clk input 1 system clock (50 MHz); reset input 1 asynchronous active-high reset.
REQ-005 SHALL have port db input 1: debounced switch level from the debouncer stage, synchronous to clk.
REQ-006 SHALL have port tick input 1: one-cycle strobe from the 10 ms mod-M ticker.
REQ-007 SHALL have ports short_p, long_p, double_p, each output 1: one-cycle classification pulses.
REQ-008 SHALL have port press_cnt output CW: count of accepted db rising edges.
REQ-009 Legal parameters SHALL be: 2 <= LONG_TICKS < 2^CW; 1 <= GAP_TICKS < 2^CW.

Function
REQ-010 Edge detect: register db_q SHALL sample db every clk; rise = db & ~db_q; fall = ~db & db_q.
REQ-011 FSM states SHALL be IDLE, HELD, LONG, GAP, HELD2.
REQ-012 Tick counter cnt SHALL clear on every state change and increment on tick while in HELD, GAP or HELD2.
REQ-013 IDLE: rise -> HELD; otherwise stay.
REQ-014 HELD: fall -> GAP; tick with cnt == LONG_TICKS-1 -> LONG and assert long_p.
REQ-015 LONG: fall -> IDLE, no pulse; no further pulses while db is held.
REQ-016 GAP: rise -> HELD2; tick with cnt == GAP_TICKS-1 -> IDLE and assert short_p.
REQ-017 HELD2: fall -> IDLE and assert double_p; tick with cnt == LONG_TICKS-1 -> LONG and assert long_p only (first press dropped, no short_p).
REQ-018 Priority: an edge (rise/fall) SHALL win over a same-cycle tick; the tick is discarded, cnt cleared, and no expiry pulse is issued.
REQ-019 Pulses SHALL be registered: high for exactly one clk cycle, starting at the clk edge that performs the transition; at most one of the three is high in any cycle.
REQ-020 press_cnt SHALL increment by 1 on every accepted rise (in IDLE or GAP) and wrap 2^CW-1 -> 0.
REQ-021 No combinational path SHALL exist from db or tick to any output.

Reset
REQ-022 On reset: state IDLE, cnt 0, short_p/long_p/double_p 0, press_cnt 0, db_q 1.
REQ-023 Reset asserted mid-press SHALL abort classification with no pulse.
REQ-024 db_q = 1 at reset SHALL prevent a button already held at reset release from counting as a press; a press counts only after db falls and rises again.

Verification (LONG_TICKS=5, GAP_TICKS=3, CW=4)
REQ-025 Reset released with db=1 held for 10 ticks, then db=0 -> no pulses; press_cnt=0.
REQ-026 Short press: rise, hold 2 ticks, fall, then 3 ticks -> short_p one cycle at the 3rd post-release tick; press_cnt=1.
REQ-027 Long press: rise, hold 12 ticks, fall -> long_p one cycle at the 5th tick only; nothing on release; press_cnt=1.
REQ-028 Double press: press 1 tick, release, re-press after 1 tick, release -> double_p one cycle on the second fall; no short_p; press_cnt=2.
REQ-029 Collision: in GAP with cnt=2, rise and tick in the same cycle -> HELD2 entered, no short_p; 17 consecutive presses -> press_cnt wraps to 1.
REQ-030 Reset pulse during HELD at cnt=3 -> all outputs 0 the same cycle; no long_p afterwards while db stays high.
